serial_byte_loader: RTL and testbench
=====================================

Name: serial_byte_loader

Overview:
Upstream stage for the 8-bit register block. Assembles a framed serial bit stream into a parallel word, MSB first. Drives the register's DATA input and issues a single-cycle ENA load strobe per completed word. Reports frame aborts on an error strobe.

Parameters:
WIDTH, 8, number of data bits per frame and width of DATA.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
SIN  input  1  serial data bit.
SVALID  input  1  SIN is sampled on this rising edge.
SFRAME  input  1  qualifies SVALID; marks the first bit of a frame.
DATA  output  WIDTH  last completed word; connects to the register's DATA input.
ENA  output  1  one-cycle load strobe; connects to the register's ENA input.
BUSY  output  1  high while a frame is partially received.
ERR  output  1  one-cycle error strobe.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset:
  - DATA=0, ENA=0, BUSY=0, ERR=0.
  - State goes to IDLE, bit counter = 0, shift register = 0.
  - A reset mid-frame discards the partial word. No ENA or ERR is issued for it.
- FSM states: IDLE and SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - SVALID=1 with SFRAME=1: sample SIN as bit WIDTH-1, set counter=1, go to SHIFT.
  - SVALID=1 with SFRAME=0: bit is ignored. No ERR, no state change.
- SHIFT:
  - Each edge with SVALID=1 and SFRAME=0: shift SIN in (MSB first) and increment the counter.
  - Edges with SVALID=0 are gaps. State, counter and shift register hold.
- Completion (sampling the WIDTH-th bit at edge N):
  - At edge N, DATA is loaded with the full word, ENA goes to 1, and the state returns to IDLE with counter=0.
  - At edge N+1, ENA returns to 0 (unless another word completes at N+1, which is impossible for WIDTH>1).
  - Latency from the last bit's sampling edge to valid DATA/ENA is 0 cycles: both are registered outputs of edge N.
- DATA stability: DATA changes only on completion and otherwise holds its value indefinitely. The register sees stable DATA whenever ENA=1.
- Abort (SVALID=1 and SFRAME=1 while in SHIFT):
  - ERR=1 for exactly one cycle.
  - The partial word is dropped and DATA is unchanged.
  - The current bit is taken as bit WIDTH-1 of a new frame (counter=1), and the FSM stays in SHIFT.
- Back-to-back frames: a new frame may start in the cycle in which ENA=1 (FSM is in IDLE). No dead cycle is required between frames.
- BUSY = 1 exactly when the state is not IDLE.
- Counter width: $clog2(WIDTH+1) bits. Must not wrap within a frame.

Optional Feature:
Macro: PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, the FSM goes to PARITY instead of completing.
  - The next SVALID with SFRAME=0 samples the even-parity bit. Good parity means the parity bit equals the XOR of the data bits.
  - Parity match: DATA/ENA update at that edge, as described for completion.
  - Parity mismatch: ERR=1 for one cycle, no ENA, DATA unchanged, return to IDLE.
  - SVALID=1 with SFRAME=1 in PARITY is an abort, handled as in SHIFT. BUSY is also high in PARITY.
- Undefined: no PARITY state and no parity logic. Completion happens on the WIDTH-th bit.

Test Plan:
- Reset, then send 8'hF0 MSB first on consecutive SVALID cycles with SFRAME on the first bit -> ENA high exactly one cycle, DATA=8'hF0, BUSY high for bits 1..7 only, ERR stays 0.
- Send 8'hEB with 2 idle (SVALID=0) cycles between every bit -> single ENA pulse, DATA=8'hEB. DATA holds the prior value 8'hF0 until the completion edge.
- Send 3 bits of a frame, then SFRAME with a full 8'h01 frame -> ERR one cycle at the abort edge, then ENA once with DATA=8'h01. No ENA for the aborted partial frame.
- Assert RST asynchronously (mid-cycle) after 5 bits of 8'hFF -> DATA=0, ENA=0, BUSY=0 immediately. After release, a full 8'hFF frame -> DATA=8'hFF.
- Send frame 8'h01 immediately followed by 8'hFF, with SFRAME on the cycle ENA=1 -> two ENA pulses 8 cycles apart, DATA=8'h01 then 8'hFF.
- With PARITY_EN: send 8'hF0 with parity 0 -> ENA, DATA=8'hF0. Then send 8'h01 with parity 0 -> ERR one cycle, no ENA, DATA remains 8'hF0.

Source files
------------

// File: rtl/serial_byte_loader.sv
// Framed serial-to-parallel loader: assembles MSB-first frames into DATA with a one-cycle ENA strobe.
// Optional even-parity check after the data bits when PARITY_EN is defined.
module serial_byte_loader #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             SFRAME,
    output logic [WIDTH-1:0] DATA,
    output logic             ENA,
    output logic             BUSY,
    output logic             ERR
);

    // state  | meaning
    // IDLE   | waiting for a framed first bit
    // SHIFT  | collecting data bits, cnt = bits received so far
    // PARITY | all data bits held in sreg, waiting for the parity bit (PARITY_EN only)
    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             ena_nxt, err_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] first;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            DATA  <= '0;
            ENA   <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
            DATA  <= data_nxt;
            ENA   <= ena_nxt;
            ERR   <= err_nxt;
        end
    end

    assign BUSY = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        data_nxt  = DATA;
        ena_nxt   = 1'b0;
        err_nxt   = 1'b0;
        word      = {sreg[WIDTH-2:0], SIN};
        first     = {{(WIDTH-1){1'b0}}, SIN};

        case (state)
            IDLE: begin
                if (SVALID && SFRAME) begin
                    sreg_nxt  = first;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (SVALID) begin
                    if (SFRAME) begin
                        // abort: current bit restarts a new frame
                        err_nxt  = 1'b1;
                        sreg_nxt = first;
                        cnt_nxt  = CW'(1);
                    end else if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
                        sreg_nxt  = word;
                        cnt_nxt   = CW'(WIDTH);
                        state_nxt = PARITY;
`else
                        sreg_nxt  = word;
                        data_nxt  = word;
                        ena_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
`endif
                    end else begin
                        sreg_nxt = word;
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (SVALID) begin
                    if (SFRAME) begin
                        err_nxt   = 1'b1;
                        sreg_nxt  = first;
                        cnt_nxt   = CW'(1);
                        state_nxt = SHIFT;
                    end else begin
                        if (SIN == ^sreg) begin
                            data_nxt = sreg;
                            ena_nxt  = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: vector table plus hand-written gap, abort-reset and parity sequences.
module tb_serial_byte_loader;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SIN = 1'b0;
    logic       SVALID = 1'b0;
    logic       SFRAME = 1'b0;
    logic [7:0] DATA;
    logic       ENA, BUSY, ERR;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic       sin, sv, sf;
        logic [7:0] data;
        logic       ena, busy, err;
    } vec_t;

    vec_t vecs[$];

    serial_byte_loader #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID), .SFRAME(SFRAME),
        .DATA(DATA), .ENA(ENA), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [7:0] d, logic e, logic b, logic r);
        chk8({tag, " DATA"}, DATA, d);
        chk1({tag, " ENA"}, ENA, e);
        chk1({tag, " BUSY"}, BUSY, b);
        chk1({tag, " ERR"}, ERR, r);
    endtask

    // drive at the falling edge, return 1ns after the sampling rising edge
    task automatic drive(logic s, logic v, logic f);
        @(negedge CLK);
        SIN = s; SVALID = v; SFRAME = f;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(logic s, logic v, logic f, logic [7:0] d, logic e, logic b, logic r);
        vec_t x;
        x.sin = s; x.sv = v; x.sf = f; x.data = d; x.ena = e; x.busy = b; x.err = r;
        vecs.push_back(x);
    endtask

    // send one 8-bit frame, MSB first, checking every edge; last edge expects prev->new
    task automatic send_frame(string tag, logic [7:0] w, logic [7:0] prev, int gaps);
        logic [7:0] v;
        v = w;
        for (int i = 7; i >= 0; i--) begin
            drive(v[i], 1'b1, i == 7);
`ifdef PARITY_EN
            chk_all($sformatf("%s bit%0d", tag, i), prev, 1'b0, 1'b1, 1'b0);
`else
            if (i == 0) chk_all($sformatf("%s bit%0d", tag, i), w, 1'b1, 1'b0, 1'b0);
            else        chk_all($sformatf("%s bit%0d", tag, i), prev, 1'b0, 1'b1, 1'b0);
`endif
            if (i != 0) begin
                for (int g = 0; g < gaps; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    chk_all($sformatf("%s gap%0d.%0d", tag, i, g), prev, 1'b0, 1'b1, 1'b0);
                end
            end
        end
    endtask

    initial begin
        #12;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

`ifdef PARITY_EN
        send_frame("par_f0", 8'hF0, 8'h00, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk_all("par_f0 good", 8'hF0, 1'b1, 1'b0, 1'b0);
        send_frame("par_01", 8'h01, 8'hF0, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk_all("par_01 bad", 8'hF0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk_all("par_01 after", 8'hF0, 1'b0, 1'b0, 1'b0);
`else
        // F0 frame, then a gap and an unframed bit ignored in IDLE
        add(1,1,1, 8'h00,0,1,0); add(1,1,0, 8'h00,0,1,0); add(1,1,0, 8'h00,0,1,0);
        add(1,1,0, 8'h00,0,1,0); add(0,1,0, 8'h00,0,1,0); add(0,1,0, 8'h00,0,1,0);
        add(0,1,0, 8'h00,0,1,0); add(0,1,0, 8'hF0,1,0,0);
        add(0,0,0, 8'hF0,0,0,0); add(1,1,0, 8'hF0,0,0,0);
        // back-to-back 01 then FF, new frame on the ENA cycle
        add(0,1,1, 8'hF0,0,1,0);
        for (int i = 0; i < 6; i++) add(0,1,0, 8'hF0,0,1,0);
        add(1,1,0, 8'h01,1,0,0);
        add(1,1,1, 8'h01,0,1,0);
        for (int i = 0; i < 6; i++) add(1,1,0, 8'h01,0,1,0);
        add(1,1,0, 8'hFF,1,0,0);
        add(0,0,0, 8'hFF,0,0,0);
        // three bits, then abort with a full 01 frame
        add(1,1,1, 8'hFF,0,1,0); add(0,1,0, 8'hFF,0,1,0); add(1,1,0, 8'hFF,0,1,0);
        add(0,1,1, 8'hFF,0,1,1);
        for (int i = 0; i < 6; i++) add(0,1,0, 8'hFF,0,1,0);
        add(1,1,0, 8'h01,1,0,0);
        add(0,0,0, 8'h01,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].sin, vecs[i].sv, vecs[i].sf);
            chk_all($sformatf("vec%0d", i), vecs[i].data, vecs[i].ena, vecs[i].busy, vecs[i].err);
        end

        // EB with two idle cycles between bits; DATA holds 01 until completion
        send_frame("eb", 8'hEB, 8'h01, 2);
        drive(1'b0, 1'b0, 1'b0);
        chk_all("eb after", 8'hEB, 1'b0, 1'b0, 1'b0);

        // reset mid-frame after five bits of FF
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        chk_all("pre-reset", 8'hEB, 1'b0, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        SVALID = 1'b0;
        #1;
        chk_all("async reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk_all("reset held", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        send_frame("ff", 8'hFF, 8'h00, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk_all("ff after", 8'hFF, 1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
